// File: rtl/merge3_sched.sv
// merge3_sched: three-channel token scheduler, JOIN (all three) or round-robin ARB, one token outstanding
module merge3_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_mode,
  input  logic             i_drive0,
  input  logic             i_drive1,
  input  logic             i_drive2,
  output logic             o_free0,
  output logic             o_free1,
  output logic             o_free2,
  output logic             o_driveNext,
  input  logic             i_freeNext,
  output logic [2:0]       o_grant,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_issueCnt,
  output logic             o_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FREE} state_t;
  state_t     state, state_nxt;
  logic [2:0] pend, pend_nxt, drv, rel, free_q;
  logic [1:0] ptr, p1, p2, win;
  logic       go, acc, err_nxt;
  // rel holds the channels released this cycle; a coincident new drive re-sets them
  always_comb begin
    drv       = {i_drive2, i_drive1, i_drive0};
    acc       = state == WAIT_FREE && i_freeNext;
    rel       = acc ? o_grant : 3'b000;
    p1        = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    p2        = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    win       = pend[ptr] ? ptr : pend[p1] ? p1 : p2;
    go        = state == IDLE && (i_mode ? |pend : &pend);
    pend_nxt  = drv | (pend & ~rel);
    err_nxt   = (i_freeNext && state != WAIT_FREE) || |(drv & pend & ~rel);
    state_nxt = state == IDLE  ? (go ? ISSUE : IDLE) :
                state == ISSUE ? WAIT_FREE :
                (acc ? IDLE : WAIT_FREE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 3'b000;
      ptr        <= 2'd0;
      o_grant    <= 3'b000;
      free_q     <= 3'b000;
      o_issueCnt <= '0;
      o_err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      free_q <= rel;
      o_err  <= o_err | err_nxt;
      if (go) begin
        o_issueCnt <= o_issueCnt + CNT_W'(1);
        o_grant    <= i_mode ? 3'b001 << win : 3'b111;
        if (i_mode) ptr <= win == 2'd2 ? 2'd0 : win + 2'd1;
      end else if (acc) begin
        o_grant <= 3'b000;
      end
    end
  end
  assign o_driveNext = state == ISSUE;
  assign o_busy      = state != IDLE;
  assign {o_free2, o_free1, o_free0} = free_q;
endmodule

// File: tb/tb_merge3_sched.sv
// tb_merge3_sched: directed checks of merge3_sched JOIN/ARB, errors, coincidence, reset and counter wrap
module tb_merge3_sched;
  logic       clk = 0, rst = 0, i_mode = 0;
  logic       i_drive0 = 0, i_drive1 = 0, i_drive2 = 0, i_freeNext = 0;
  logic       o_free0, o_free1, o_free2, o_driveNext, o_busy, o_err;
  logic [2:0] o_grant;
  logic [1:0] o_issueCnt;
  int         n_run = 0, n_fail = 0;
  merge3_sched #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode),
    .i_drive0(i_drive0), .i_drive1(i_drive1), .i_drive2(i_drive2),
    .o_free0(o_free0), .o_free1(o_free1), .o_free2(o_free2),
    .o_driveNext(o_driveNext), .i_freeNext(i_freeNext),
    .o_grant(o_grant), .o_busy(o_busy), .o_issueCnt(o_issueCnt), .o_err(o_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [2:0] d, input logic f);
    {i_drive2, i_drive1, i_drive0} = d;
    i_freeNext = f;
    tick();
    {i_drive2, i_drive1, i_drive0} = 3'b000;
    i_freeNext = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic wait_token(input string tag);
    int i;
    for (i = 0; i < 8 && !o_driveNext; i++) tick();
    if (!o_driveNext) chk({tag, "_timeout"}, 0, 1);
  endtask
  task automatic run_join(input string tag);
    i_mode = 0;
    pulse(3'b001, 0);
    tick();
    pulse(3'b010, 0);
    tick();
    chk({tag, "_partial_no_token"}, o_driveNext, 0);
    pulse(3'b100, 0);
    chk({tag, "_t6_no_token"}, o_driveNext, 0);
    tick();
    chk({tag, "_t7_token"}, o_driveNext, 1);
    chk({tag, "_t7_grant"}, o_grant, 3'b111);
    chk({tag, "_t7_cnt"}, o_issueCnt, 1);
    tick();
    chk({tag, "_t8_pulse_end"}, o_driveNext, 0);
    chk({tag, "_t8_busy"}, o_busy, 1);
    tick();
    tick();
    pulse(3'b000, 1);
    chk({tag, "_t11_free"}, {o_free2, o_free1, o_free0}, 3'b111);
    chk({tag, "_t11_busy"}, o_busy, 0);
    chk({tag, "_t11_grant"}, o_grant, 0);
    chk({tag, "_err"}, o_err, 0);
    tick();
    chk({tag, "_free_one_cycle"}, {o_free2, o_free1, o_free0}, 0);
  endtask
  initial begin
    do_reset();
    chk("rst_busy", o_busy, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_cnt", o_issueCnt, 0);
    chk("rst_err", o_err, 0);
    chk("rst_free", {o_free2, o_free1, o_free0}, 0);
    chk("rst_drive", o_driveNext, 0);
    run_join("join");
    // ARB fairness: all three pending, grants rotate 001, 010, 100
    do_reset();
    i_mode = 1;
    pulse(3'b111, 0);
    for (int k = 0; k < 3; k++) begin
      wait_token("arb");
      chk($sformatf("arb_grant%0d", k), o_grant, 3'b001 << k);
      chk($sformatf("arb_cnt%0d", k), o_issueCnt, k + 1);
      tick();
      pulse(3'b000, 1);
      chk($sformatf("arb_free%0d", k), {o_free2, o_free1, o_free0}, 3'b001 << k);
    end
    repeat (4) tick();
    chk("arb_drained_busy", o_busy, 0);
    chk("arb_drained_cnt", o_issueCnt, 3);
    chk("arb_err", o_err, 0);
    // freeNext while idle
    do_reset();
    pulse(3'b000, 1);
    chk("err_free_idle", o_err, 1);
    chk("err_free_idle_busy", o_busy, 0);
    tick();
    chk("err_free_idle_sticky", o_err, 1);
    // double drive on ch1
    do_reset();
    i_mode = 1;
    pulse(3'b010, 0);
    chk("dbl_no_err_yet", o_err, 0);
    pulse(3'b010, 0);
    chk("dbl_err", o_err, 1);
    wait_token("dbl");
    chk("dbl_grant", o_grant, 3'b010);
    tick();
    pulse(3'b000, 1);
    repeat (4) tick();
    chk("dbl_single_token", o_issueCnt, 1);
    chk("dbl_idle", o_busy, 0);
    // drive0 coincides with accepted free of ch0
    do_reset();
    i_mode = 1;
    pulse(3'b001, 0);
    wait_token("coin");
    tick();
    pulse(3'b001, 1);
    chk("coin_free0", {o_free2, o_free1, o_free0}, 3'b001);
    chk("coin_err", o_err, 0);
    wait_token("coin2");
    chk("coin_regrant", o_grant, 3'b001);
    chk("coin_cnt", o_issueCnt, 2);
    // reset mid-token, with a free attempted in the same cycle
    do_reset();
    i_mode = 0;
    pulse(3'b111, 0);
    wait_token("mid");
    tick();
    chk("mid_waiting", o_busy, 1);
    rst = 1;
    pulse(3'b000, 1);
    rst = 0;
    chk("mid_free", {o_free2, o_free1, o_free0}, 0);
    chk("mid_grant", o_grant, 0);
    chk("mid_busy", o_busy, 0);
    chk("mid_cnt", o_issueCnt, 0);
    chk("mid_err", o_err, 0);
    tick();
    chk("mid_no_late_free", {o_free2, o_free1, o_free0}, 0);
    run_join("rejoin");
    // 2-bit counter wrap
    do_reset();
    i_mode = 1;
    for (int i = 0; i < 5; i++) begin
      pulse(3'b001, 0);
      wait_token("wrap");
      chk($sformatf("wrap_cnt%0d", i), o_issueCnt, (i + 1) % 4);
      tick();
      pulse(3'b000, 1);
    end
    chk("wrap_err", o_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/merge3_sched.md
MERGE3_SCHED -- requirements
Module: merge3_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the issued-token counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_mode, input, 1 bit: 0 = JOIN (wait for all three), 1 = ARB (round-robin, one channel per token).
REQ-005 SHALL have ports i_drive0/i_drive1/i_drive2, input, 1 bit each: one-cycle request pulse from channel k.
REQ-006 SHALL have ports o_free0/o_free1/o_free2, output, 1 bit each: one-cycle release pulse to channel k.
REQ-007 SHALL have port o_driveNext, output, 1 bit: one-cycle token pulse to downstream.
REQ-008 SHALL have port i_freeNext, input, 1 bit: one-cycle release pulse from downstream.
REQ-009 SHALL have port o_grant, output, 3 bits: channels in the current token (111 in JOIN, one-hot in ARB); 000 when idle.
REQ-010 SHALL have port o_busy, output, 1 bit: high whenever FSM is not IDLE.
REQ-011 SHALL have port o_issueCnt, output, CNT_W bits: count of tokens issued.
REQ-012 SHALL have port o_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 SHALL keep a pending bit pend[k] per channel; i_drivek=1 at an edge sets pend[k].
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_FREE; all outputs registered.
REQ-015 SHALL sample i_mode only in IDLE; changes while busy take effect at the next IDLE decision.
REQ-016 SHALL, in IDLE with mode JOIN, move to ISSUE with grant=111 when registered pend==111; otherwise stay.
REQ-017 SHALL, in IDLE with mode ARB, move to ISSUE granting the first pending channel searching ptr, ptr+1, ptr+2 (mod 3); ptr then becomes winner+1 mod 3.
REQ-018 SHALL evaluate only registered pend in IDLE (drive in cycle t visible to decision at t+1; o_driveNext high at t+2 at earliest).
REQ-019 SHALL assert o_driveNext for exactly the one cycle the FSM is in ISSUE, then go to WAIT_FREE.
REQ-020 SHALL increment o_issueCnt on entry to ISSUE, wrapping from 2^CNT_W-1 to 0.
REQ-021 SHALL, in WAIT_FREE on i_freeNext=1, pulse o_freek for one cycle for every granted k, clear those pend bits, clear o_grant, return to IDLE.
REQ-022 SHALL, when i_drivek coincides with the accepted i_freeNext for granted k, leave pend[k] set (new request wins) without error.
REQ-023 SHALL treat i_drivek while pend[k] already set (other than REQ-022) as an error: set o_err, drop the pulse.
REQ-024 SHALL treat i_freeNext outside WAIT_FREE as an error: set o_err, no other effect.
REQ-025 SHALL never issue a new token before the previous token's free has been accepted (at most one token outstanding).
REQ-026 SHALL leave non-granted pend bits untouched by a free, so ARB never starves a pending channel beyond two other tokens.

Reset
REQ-027 SHALL, with rst=1 at an edge, force state IDLE, pend=000, ptr=0, o_grant=000, o_driveNext=0, o_free0..2=0, o_busy=0, o_issueCnt=0, o_err=0.
REQ-028 SHALL let reset override everything, including mid-token (ISSUE/WAIT_FREE): the outstanding token is abandoned and no o_free pulse is generated.
REQ-029 SHALL ignore i_drive/i_freeNext in any cycle with rst=1.

Verification
REQ-030 JOIN: drive0@t1, drive1@t3, drive2@t5 -> o_driveNext only at t7, o_grant=111, cnt=1; freeNext@t10 -> o_free0/1/2 all high at t11, busy low at t11.
REQ-031 ARB fairness: all three drives at t1, freeNext one cycle after each driveNext -> grants 001, 010, 100 in order, cnt=3, pend=000 at end.
REQ-032 Errors: freeNext in IDLE -> o_err=1, state unchanged; fresh bench, drive1 twice while pending -> o_err=1, single token issued for ch1.
REQ-033 Coincidence: ARB, grant=001 in WAIT_FREE, drive0 and freeNext same cycle -> o_free0 pulse, pend[0]=1, o_err=0, second token for ch0 issued (ptr skips to 1,2 first only if pending).
REQ-034 Reset mid-token: rst during WAIT_FREE -> next cycle all outputs at reset values, no o_free pulse; subsequent JOIN sequence behaves as REQ-030.
REQ-035 Wrap: CNT_W=2, issue 5 ARB tokens -> o_issueCnt sequence 1,2,3,0,1.
